// File: rtl/adder_pkg.sv
// Shared state encoding, width legality check and helpers for multicycle_adder.
// ADDER_CHECK_WIDTH(W, C) rejects parameter sets where C does not evenly divide W.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

`define ADDER_CHECK_WIDTH(W, C) \
  if ((C) == 0 || (C) > (W) || ((W) % (C)) != 0) begin : g_bad_width \
    $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK"); \
  end

package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Counter width that stays legal when only one chunk exists.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder made of full-adder cells; purely combinational.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic             ci,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

  assign co = w_c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell built from two half-adders.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.x(x),    .y(y),  .s(w_s0), .c(w_c0));
  half_adder u_ha1 (.x(w_s0), .y(ci), .s(s),    .c(w_c1));

  assign co = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half-adder cell.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder that processes CHUNK bits per cycle with a registered carry.
// Define MULTICYCLE_ADDER_SUB_EN to add the sub port (A + ~B + 1 when sub=1).
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef MULTICYCLE_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  import adder_pkg::*;

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);

  `ADDER_CHECK_WIDTH(WIDTH, CHUNK)

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cy;
  logic             w_accept;
  logic             w_last;
  logic             w_cy_init;
  logic             w_inv_b;
  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_s;
  logic             w_co;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(NCHUNK - 1));
  assign w_base   = 32'(r_cnt) * 32'(CHUNK);

`ifdef MULTICYCLE_ADDER_SUB_EN
  logic r_sub;

  // Subtraction is two's complement: invert B and seed the carry with 1.
  assign w_cy_init = sub;
  assign w_inv_b   = r_sub;
`else
  assign w_cy_init = 1'b0;
  assign w_inv_b   = 1'b0;
`endif

  assign w_x = r_a[w_base +: CHUNK];
  assign w_y = w_inv_b ? ~r_b[w_base +: CHUNK] : r_b[w_base +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .ci (r_cy),
    .x  (w_x),
    .y  (w_y),
    .s  (w_s),
    .co (w_co)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      in_ready  <= (w_state_nxt == ST_IDLE);
      out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture and chunk-serial accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_cy  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef MULTICYCLE_ADDER_SUB_EN
      r_sub <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_cnt <= '0;
      r_cy  <= w_cy_init;
`ifdef MULTICYCLE_ADDER_SUB_EN
      r_sub <= sub;
`endif
    end else if (r_state == ST_RUN) begin
      sum[w_base +: CHUNK] <= w_s;
      r_cy                 <= w_co;
      r_cnt                <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_last) carry <= w_co;
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench: WIDTH=16 with CHUNK=4 and the CHUNK=16 corner.
module tb_multicycle_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry;

  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [15:0] sum1;
  logic        carry1;

`ifdef MULTICYCLE_ADDER_SUB_EN
  logic        sub_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef MULTICYCLE_ADDER_SUB_EN
    ,
    .sub       (sub_s)
`endif
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .carry     (carry1)
`ifdef MULTICYCLE_ADDER_SUB_EN
    ,
    .sub       (sub_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction on the CHUNK=4 instance; operands are scrambled after accept.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] es, input logic ec, input string tag);
    int lat;
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a        = ~ta;
    b        = tb_v ^ 16'h5A5A;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " carry"}, 32'(carry), 32'(ec));
    chk({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    a1         = '0;
    b1         = '0;
`ifdef MULTICYCLE_ADDER_SUB_EN
    sub_s      = 1'b0;
`endif
    step();
    step();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset carry", 32'(carry), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0F0F, 16'h2143, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1, "carry chain");
    run_op(16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, "no carry all ones");
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, "max plus max");

    // Backpressure: hold DONE for 10 cycles while offering new operands.
    a        = 16'h1234;
    b        = 16'h0F0F;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a        = 16'hFFFF;
      b        = 16'hFFFF;
      step();
      chk("bp hold out_valid", 32'(out_valid), 32'd1);
      chk("bp hold sum", 32'(sum), 32'h2143);
      chk("bp hold carry", 32'(carry), 32'd0);
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp no stray accept", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle discards the operation.
    a        = 16'h1111;
    b        = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort carry", 32'(carry), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort never presented", 32'(out_valid), 32'd0);
    end
    run_op(16'h0003, 16'h0004, 16'h0007, 1'b0, "after abort");

`ifdef MULTICYCLE_ADDER_SUB_EN
    sub_s = 1'b1;
    run_op(16'h0005, 16'h0007, 16'hFFFE, 1'b0, "sub 5-7");
    run_op(16'h0007, 16'h0005, 16'h0002, 1'b1, "sub 7-5");
    sub_s = 1'b0;
    run_op(16'h0007, 16'h0005, 16'h000C, 1'b0, "add after sub");
`endif

    // Single-chunk instance: latency of one cycle.
    a1        = 16'h8000;
    b1        = 16'h8000;
    in_valid1 = 1'b1;
    chk("c16 in_ready", 32'(in_ready1), 32'd1);
    step();
    in_valid1 = 1'b0;
    a1        = 16'h1234;
    b1        = 16'h4321;
    chk("c16 out_valid in RUN", 32'(out_valid1), 32'd0);
    step();
    chk("c16 out_valid", 32'(out_valid1), 32'd1);
    chk("c16 sum", 32'(sum1), 32'h0000);
    chk("c16 carry", 32'(carry1), 32'd1);
    chk("c16 in_ready in DONE", 32'(in_ready1), 32'd0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("c16 handoff out_valid", 32'(out_valid1), 32'd0);
    chk("c16 handoff in_ready", 32'(in_ready1), 32'd1);

    a1        = 16'h1234;
    b1        = 16'h0F0F;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    step();
    chk("c16 basic out_valid", 32'(out_valid1), 32'd1);
    chk("c16 basic sum", 32'(sum1), 32'h2143);
    chk("c16 basic carry", 32'(carry1), 32'd0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
